// File: rtl/regfile_pkg.sv
// Shared constants, register names and the write-port arbitration helper
// for the multi-ported register file.
package regfile_pkg;

  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 5;
  localparam int MAX_WR     = 8;
  localparam int MAX_ADDR_W = 16;

  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;
  localparam logic [ADDR_W-1:0] REG_RA   = 5'd1;
  localparam logic [ADDR_W-1:0] REG_SP   = 5'd2;
  localparam logic [ADDR_W-1:0] REG_A0   = 5'd10;
  localparam logic [ADDR_W-1:0] REG_A7   = 5'd17;

  typedef struct packed {
    logic       hit;
    logic [2:0] idx;
  } wr_win_t;

  // Callers zero-pad we/rd up to MAX_WR ports. The scan runs upward, so the
  // last match it records is the highest-indexed port.
  function automatic wr_win_t f_wr_winner(
    input logic [MAX_WR-1:0]                 we,
    input logic [MAX_WR-1:0][MAX_ADDR_W-1:0] rd,
    input logic [MAX_ADDR_W-1:0]             addr
  );
    wr_win_t w;
    w = '0;
    for (int j = 0; j < MAX_WR; j++) begin
      if (we[j] && rd[j] == addr) begin
        w.hit = 1'b1;
        w.idx = 3'(j);
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Decode/writeback-facing bus of the multi-ported register file.
interface regfile_mp_if #(
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int ADDR_W = regfile_pkg::ADDR_W,
  parameter int NRD    = 2,
  parameter int NWR    = 1
);
  logic [NRD-1:0][ADDR_W-1:0] rs;
  logic [NRD-1:0][DATA_W-1:0] rdata;
  logic [NRD-1:0]             rs_busy;
  logic [NWR-1:0]             we;
  logic [NWR-1:0][ADDR_W-1:0] rd;
  logic [NWR-1:0][DATA_W-1:0] din;
  logic                       iss_valid;
  logic [ADDR_W-1:0]          iss_rd;
  logic [ADDR_W-1:0]          dbg_sel;
  logic [DATA_W-1:0]          dbg_data;

  modport master (
    output rs, we, rd, din, iss_valid, iss_rd, dbg_sel,
    input  rdata, rs_busy, dbg_data
  );

  modport slave (
    input  rs, we, rd, din, iss_valid, iss_rd, dbg_sel,
    output rdata, rs_busy, dbg_data
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits used for RAW hazard detection.
// An issue to a register overrides a write that clears it in the same cycle.
module regfile_scoreboard #(
  parameter int ADDR_W = regfile_pkg::ADDR_W,
  parameter int NRD    = 2,
  parameter int BYPASS = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       iss_valid,
  input  logic [ADDR_W-1:0]          iss_rd,
  input  logic [2**ADDR_W-1:0]       clr,
  input  logic [NRD-1:0][ADDR_W-1:0] rs,
  output logic [NRD-1:0]             rs_busy
);
  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0] busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      for (int k = 1; k < DEPTH; k++)
        busy[k] <= (iss_valid && iss_rd == ADDR_W'(k)) || (busy[k] && !clr[k]);
    end
  end

  always_comb begin
    rs_busy = '0;
    for (int i = 0; i < NRD; i++)
      rs_busy[i] = (rs[i] != '0) && busy[rs[i]] && !((BYPASS != 0) && clr[rs[i]]);
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-ported register file: NRD combinational reads, NWR prioritised writes,
// optional write-to-read forwarding, x0 hardwired to zero, and a debug tap.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int ADDR_W = regfile_pkg::ADDR_W,
  parameter int NRD    = 2,
  parameter int NWR    = 1,
  parameter int BYPASS = 1
) (
  input logic         clk,
  input logic         rst_n,
  regfile_mp_if.slave bus
);
  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0]                mem     [DEPTH];
  logic [DATA_W-1:0]                wr_data [DEPTH];
  logic [DEPTH-1:0]                 wr_hit;
  logic [MAX_WR-1:0]                we_pad;
  logic [MAX_WR-1:0][MAX_ADDR_W-1:0] rd_pad;
  wr_win_t                          ww;
  wr_win_t                          rw;

  function automatic logic [DATA_W-1:0] f_pick(
    input logic [2:0]                   idx,
    input logic [NWR-1:0][DATA_W-1:0]   din
  );
    logic [DATA_W-1:0] v;
    v = '0;
    for (int j = 0; j < NWR; j++)
      if (int'(idx) == j) v = din[j];
    return v;
  endfunction

  always_comb begin
    we_pad = '0;
    rd_pad = '0;
    for (int j = 0; j < NWR; j++) begin
      we_pad[j] = bus.we[j];
      rd_pad[j] = MAX_ADDR_W'(bus.rd[j]);
    end
  end

  // Winning write port per register; x0 never takes a write.
  always_comb begin
    ww     = '0;
    wr_hit = '0;
    for (int k = 0; k < DEPTH; k++) begin
      ww         = f_wr_winner(we_pad, rd_pad, MAX_ADDR_W'(k));
      wr_hit[k]  = ww.hit && (k != 0);
      wr_data[k] = f_pick(ww.idx, bus.din);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
    end else begin
      for (int k = 1; k < DEPTH; k++)
        if (wr_hit[k]) mem[k] <= wr_data[k];
    end
  end

  // Forwarding is gated by rst_n so outputs read zero throughout reset.
  always_comb begin
    rw        = '0;
    bus.rdata = '0;
    for (int i = 0; i < NRD; i++) begin
      rw = f_wr_winner(we_pad, rd_pad, MAX_ADDR_W'(bus.rs[i]));
      bus.rdata[i] = (bus.rs[i] == '0) ? '0 : mem[bus.rs[i]];
      if ((BYPASS != 0) && rst_n && (bus.rs[i] != '0) && rw.hit)
        bus.rdata[i] = f_pick(rw.idx, bus.din);
    end
  end

  assign bus.dbg_data = (bus.dbg_sel == '0) ? '0 : mem[bus.dbg_sel];

  regfile_scoreboard #(
    .ADDR_W (ADDR_W),
    .NRD    (NRD),
    .BYPASS (BYPASS)
  ) u_sb (
    .clk       (clk),
    .rst_n     (rst_n),
    .iss_valid (bus.iss_valid),
    .iss_rd    (bus.iss_rd),
    .clr       (wr_hit),
    .rs        (bus.rs),
    .rs_busy   (bus.rs_busy)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Drives a forwarding and a non-forwarding register file with identical stimulus
// and scores both against a behavioural model through an expectation queue.
module tb_regfile_mp;
  logic clk;
  logic rst_n;

  regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .NRD(2), .NWR(2)) bus1 ();
  regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .NRD(2), .NWR(2)) bus0 ();

  assign bus0.rs        = bus1.rs;
  assign bus0.we        = bus1.we;
  assign bus0.rd        = bus1.rd;
  assign bus0.din       = bus1.din;
  assign bus0.iss_valid = bus1.iss_valid;
  assign bus0.iss_rd    = bus1.iss_rd;
  assign bus0.dbg_sel   = bus1.dbg_sel;

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NRD(2), .NWR(2), .BYPASS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1));
  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NRD(2), .NWR(2), .BYPASS(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0][31:0] rd1;
    logic [1:0][31:0] rd0;
    logic [1:0]       bz1;
    logic [1:0]       bz0;
    logic [31:0]      dbg;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] regs_m [32];
  bit          busy_m [32];
  int          errs   = 0;
  int          checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask

  // One cycle of stimulus: expectation for this cycle is queued, then the
  // model advances to the state the next rising edge should produce.
  task automatic step(input logic [1:0] we, input logic [4:0] rd0, input logic [4:0] rd1,
                      input logic [31:0] d0, input logic [31:0] d1,
                      input logic iv, input logic [4:0] ird,
                      input logic [4:0] rs0, input logic [4:0] rs1, input logic [4:0] dsel);
    exp_t        e;
    logic [4:0]  wrd [2];
    logic [31:0] wd  [2];
    logic [4:0]  a;
    bit          hit;
    logic [31:0] hv;
    @(posedge clk); #1;
    bus1.we = we; bus1.rd[0] = rd0; bus1.rd[1] = rd1;
    bus1.din[0] = d0; bus1.din[1] = d1;
    bus1.iss_valid = iv; bus1.iss_rd = ird;
    bus1.rs[0] = rs0; bus1.rs[1] = rs1; bus1.dbg_sel = dsel;
    wrd[0] = rd0; wrd[1] = rd1; wd[0] = d0; wd[1] = d1;
    e = '0;
    for (int i = 0; i < 2; i++) begin
      a = (i == 0) ? rs0 : rs1;
      hit = 0; hv = '0;
      for (int j = 0; j < 2; j++)
        if (we[j] && wrd[j] == a) begin hit = 1; hv = wd[j]; end
      e.rd0[i] = (a == 0) ? 32'h0 : regs_m[a];
      e.rd1[i] = (a != 0 && hit) ? hv : e.rd0[i];
      e.bz0[i] = (a != 0) && busy_m[a];
      e.bz1[i] = e.bz0[i] && !hit;
    end
    e.dbg = (dsel == 0) ? 32'h0 : regs_m[dsel];
    sbq.push_back(e);
    for (int j = 0; j < 2; j++) begin
      if (we[j] && wrd[j] != 0) regs_m[wrd[j]] = wd[j];
      if (we[j]) busy_m[wrd[j]] = 0;
    end
    if (iv && ird != 0) busy_m[ird] = 1;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        for (int i = 0; i < 2; i++) begin
          chk($sformatf("rdata_byp%0d", i),  bus1.rdata[i],          e.rd1[i]);
          chk($sformatf("rdata_nobyp%0d", i), bus0.rdata[i],         e.rd0[i]);
          chk($sformatf("busy_byp%0d", i),   32'(bus1.rs_busy[i]),   32'(e.bz1[i]));
          chk($sformatf("busy_nobyp%0d", i), 32'(bus0.rs_busy[i]),   32'(e.bz0[i]));
        end
        chk("dbg_byp",   bus1.dbg_data, e.dbg);
        chk("dbg_nobyp", bus0.dbg_data, e.dbg);
      end
    end
  end

  initial begin
    for (int k = 0; k < 32; k++) begin regs_m[k] = '0; busy_m[k] = 0; end
    rst_n = 1'b0;
    bus1.we = '0; bus1.rd = '0; bus1.din = '0; bus1.iss_valid = 1'b0;
    bus1.iss_rd = '0; bus1.rs = '0; bus1.dbg_sel = '0;
    bus1.rs[0] = 5'd5; bus1.dbg_sel = 5'd10;
    #2;
    chk("reset_rdata", bus1.rdata[0], 32'h0);
    chk("reset_dbg",   bus0.dbg_data, 32'h0);
    chk("reset_busy",  32'(bus1.rs_busy), 32'h0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    for (int k = 0; k < 16; k++)
      step(2'b00, 0, 0, 0, 0, 0, 0, 5'(2*k), 5'(2*k+1), 5'(k));

    step(2'b11, 7, 7, 32'h5555, 32'hAAAA, 0, 0, 7, 0, 7);
    step(2'b00, 0, 0, 0, 0, 0, 0, 7, 7, 7);
    step(2'b01, 0, 0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0);
    step(2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    step(2'b01, 10, 0, 32'hDEAD_BEEF, 0, 0, 0, 10, 10, 10);
    step(2'b00, 0, 0, 0, 0, 0, 0, 10, 0, 10);

    step(2'b00, 0, 0, 0, 0, 1, 17, 17, 17, 0);
    step(2'b00, 0, 0, 0, 0, 0, 0, 17, 17, 0);
    step(2'b10, 0, 17, 0, 32'h1717, 0, 0, 17, 17, 17);
    step(2'b00, 0, 0, 0, 0, 0, 0, 17, 17, 17);
    step(2'b00, 0, 0, 0, 0, 1, 17, 17, 0, 0);
    step(2'b01, 17, 0, 32'h2222, 0, 1, 17, 17, 17, 17);
    step(2'b00, 0, 0, 0, 0, 0, 0, 17, 17, 17);

    step(2'b01, 10, 0, 32'h42, 0, 0, 0, 10, 1, 10);
    step(2'b00, 0, 0, 0, 0, 0, 0, 10, 1, 10);
    step(2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    for (int n = 0; n < 400; n++)
      step(2'($urandom_range(0, 3)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
           $urandom, $urandom, 1'($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)),
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));

    repeat (3) @(negedge clk);
    checks++;
    if (sbq.size() != 0) begin
      errs++;
      $display("FAIL queue_drain got=%0d expected=0", sbq.size());
    end

    // Asynchronous reset in the middle of a pending write.
    @(posedge clk); #1;
    bus1.we = 2'b01; bus1.rd[0] = 5'd5; bus1.din[0] = 32'h1234;
    bus1.iss_valid = 1'b1; bus1.iss_rd = 5'd5;
    @(posedge clk); #1;
    bus1.din[0] = 32'h9999; bus1.iss_valid = 1'b0;
    bus1.rs[0] = 5'd5; bus1.dbg_sel = 5'd5;
    #1;
    chk("pre_rst_x5",   bus0.rdata[0], 32'h1234);
    chk("pre_rst_busy", 32'(bus0.rs_busy[0]), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_x5_byp",   bus1.rdata[0], 32'h0);
    chk("rst_x5_nobyp", bus0.rdata[0], 32'h0);
    chk("rst_dbg",      bus0.dbg_data, 32'h0);
    chk("rst_busy",     32'(bus1.rs_busy[0]), 32'h0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    bus1.we = 2'b00;
    #1;
    chk("post_rst_x5", bus0.rdata[0], 32'h0);
    bus1.we = 2'b01; bus1.din[0] = 32'h77;
    @(posedge clk); #1;
    bus1.we = 2'b00;
    chk("first_write_x5", bus0.rdata[0], 32'h77);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
